// File: rtl/mmu_conv_sched.sv
// mmu_conv_sched: frame sequencer for the MMU 3x3 convolution path.
// One accepted start configures the CFIFO, streams every pixel of the
// frame from X-RAM in raster order, tags full-window beats and advances
// the Y-RAM write address for each one.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready, waiting for start
// CFG    | single cycle: CFIFO configuration strobe and line-buffer clear
// STREAM | issue one pixel read per cycle in which core_ready is high
// DRAIN  | last issued beat is being returned from X-RAM
// DONE   | single-cycle done pulse (also taken on a rejected start)
module mmu_conv_sched #(
    parameter int VAW        = 12,
    parameter int MAW        = 10,
    parameter int FIFO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ready,
    input  logic [FIFO_WIDTH-1:0] img_w,
    input  logic [FIFO_WIDTH-1:0] img_h,
    input  logic [VAW-1:0]        x_base,
    input  logic [VAW-1:0]        y_base,
    input  logic [MAW-1:0]        w_base,
    input  logic                  core_ready,
    output logic [VAW-1:0]        X_rd,
    output logic [MAW-1:0]        W_rd,
    output logic                  cfifo_cfg,
    output logic [FIFO_WIDTH-1:0] cfifo_cfg_len,
    output logic                  cfifo_load0,
    output logic                  cfifo_dvalid,
    output logic                  win_valid,
    output logic [VAW-1:0]        Y_wr,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [FIFO_WIDTH-1:0] r_w;
    logic [FIFO_WIDTH-1:0] r_h;
    logic [FIFO_WIDTH-1:0] r_col;
    logic [FIFO_WIDTH-1:0] r_row;
    logic [VAW-1:0]        r_x_ptr;
    logic [VAW-1:0]        r_y_ptr;
    logic [MAW-1:0]        r_w_rd;
    logic [FIFO_WIDTH-1:0] r_cfg_len;

    logic                  r_ready;
    logic                  r_cfg;
    logic                  r_dvalid;
    logic                  r_win;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_dim_ok;
    logic                  w_issue;
    logic                  w_col_last;
    logic                  w_last;

    logic                  w_ready_nxt;
    logic                  w_cfg_nxt;
    logic                  w_dvalid_nxt;
    logic                  w_win_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;

    localparam logic [FIFO_WIDTH-1:0] C_TWO   = FIFO_WIDTH'(2);
    localparam logic [FIFO_WIDTH-1:0] C_THREE = FIFO_WIDTH'(3);

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_dim_ok   = (img_w >= C_THREE) && (img_h >= C_THREE);
    assign w_issue    = (r_state == S_STREAM) && core_ready;
    assign w_col_last = (r_col == r_w - 1'b1);
    assign w_last     = w_issue && w_col_last && (r_row == r_h - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = w_dim_ok ? S_CFG : S_DONE;
            S_CFG:    w_state_nxt = S_STREAM;
            S_STREAM: if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN:  w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: values the output registers take at the next edge
    always_comb begin
        w_ready_nxt  = (w_state_nxt == S_IDLE);
        w_cfg_nxt    = (w_state_nxt == S_CFG);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_dvalid_nxt = w_issue;
        w_win_nxt    = w_issue && (r_row >= C_TWO) && (r_col >= C_TWO);
        w_err_nxt    = w_accept ? !w_dim_ok : r_err;
    end

    // Registered strobes and status; row/col tags travel with the beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready  <= 1'b1;
            r_cfg    <= 1'b0;
            r_dvalid <= 1'b0;
            r_win    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_cfg    <= w_cfg_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_win    <= w_win_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Descriptor latch, raster counters and running address pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w       <= '0;
            r_h       <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_x_ptr   <= '0;
            r_y_ptr   <= '0;
            r_w_rd    <= '0;
            r_cfg_len <= '0;
        end else if (w_accept && w_dim_ok) begin
            r_w       <= img_w;
            r_h       <= img_h;
            r_col     <= '0;
            r_row     <= '0;
            r_x_ptr   <= x_base;
            r_y_ptr   <= y_base;
            r_w_rd    <= w_base;
            r_cfg_len <= img_w;
        end else begin
            if (w_issue) begin
                r_x_ptr <= r_x_ptr + 1'b1;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (r_win) begin
                r_y_ptr <= r_y_ptr + 1'b1;
            end
        end
    end

    assign ready         = r_ready;
    assign cfifo_cfg     = r_cfg;
    assign cfifo_load0   = r_cfg;
    assign cfifo_cfg_len = r_cfg_len;
    assign cfifo_dvalid  = r_dvalid;
    assign win_valid     = r_win;
    assign done          = r_done;
    assign err           = r_err;
    assign X_rd          = r_x_ptr;
    assign Y_wr          = r_y_ptr;
    assign W_rd          = r_w_rd;

endmodule

// File: doc/mmu_conv_sched.md
# mmu_conv_sched

Sequencer for the memory management unit's convolution path. It takes one frame descriptor (base addresses, image width and height) and drives the following, so that one `start` runs a complete 3x3 sliding-window pass over a single-channel image:

- the X-RAM read port,
- the CFIFO line-buffer configuration and data-valid strobes,
- the W-RAM read address,
- the Y-RAM write port.

It replaces manual `cmd`/`start`/`ready` driving by the host and sits between the host interface and the MMU top level.

## Interface
Parameters:
- `VAW`, 12, X/Y RAM address width
- `MAW`, 10, W RAM address width
- `FIFO_WIDTH`, 8, width of image dimension fields and CFIFO length

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  launch a frame; honoured only while `ready`=1
- `ready`  out  1  idle, accepting `start`
- `img_w`, `img_h`  in  `FIFO_WIDTH`  image dimensions in pixels, latched at start
- `x_base`, `y_base`  in  `VAW`  source/destination base addresses, latched at start
- `w_base`  in  `MAW`  weight set address, latched at start
- `core_ready`  in  1  core can accept a pixel beat one cycle later
- `X_rd`  out  `VAW`  X-RAM read address
- `W_rd`  out  `MAW`  W-RAM read address, held for whole frame
- `cfifo_cfg`  out  1  one-cycle CFIFO configuration strobe
- `cfifo_cfg_len`  out  `FIFO_WIDTH`  line length, valid with `cfifo_cfg`
- `cfifo_load0`  out  1  one-cycle line-buffer clear, coincident with `cfifo_cfg`
- `cfifo_dvalid`  out  1  pixel beat from X-RAM valid for CFIFO this cycle
- `win_valid`  out  1  this beat completes a full 3x3 window (KP valid)
- `Y_wr`  out  `VAW`  Y-RAM write address, valid with `win_valid`
- `done`  out  1  one-cycle end-of-frame pulse
- `err`  out  1  last start rejected (dimension < 3); sticky until next accepted start

## Operation
- All outputs are registered. Reset values: `ready`=1; every other output 0; FSM in `IDLE`.
- States and transitions:
  - `IDLE`: `ready`=1. `start`=1 latches all descriptor inputs and clears `err`. If `img_w`<3 or `img_h`<3, go to `DONE` with `err`=1. Otherwise go to `CFG`. While in any other state, `start` is ignored.
  - `CFG`: exactly one cycle with `cfifo_cfg`=1, `cfifo_load0`=1 and `cfifo_cfg_len`=`img_w`. `W_rd`=`w_base` from here until `DONE`. Next state is `STREAM`.
  - `STREAM`: raster counters `col` (0..`img_w`-1) and `row` (0..`img_h`-1). An issue occurs when `core_ready`=1.
    - On an issue, `X_rd`=`x_base`+`row`*`img_w`+`col`, implemented as a running pointer incremented by 1 with no multiplier. `col` then advances, wrapping to 0 and incrementing `row`.
    - When `core_ready`=0, `X_rd` and the counters hold.
    - The issue of pixel (`img_h`-1,`img_w`-1) moves the FSM to `DRAIN`.
  - `DRAIN`: one cycle that waits for the last returned beat. Next state is `DONE`.
  - `DONE`: `done`=1 for one cycle. Next state is `IDLE`.
- Data-valid pipeline:
  - `cfifo_dvalid`(t) = issue(t-1), matching the 1-cycle X-RAM read latency.
  - A beat already issued is always delivered, even if `core_ready` drops.
  - `win_valid` = `cfifo_dvalid` AND issued `row`>=2 AND issued `col`>=2. Row and column tags are delayed alongside `dvalid`.
- `Y_wr` counter: loads `y_base` at start and increments by 1 after each `win_valid` beat. The frame produces (`img_w`-2)*(`img_h`-2) outputs.
- Address arithmetic: all address pointers wrap modulo 2^`VAW` (2^`MAW` for W). No overflow flag.
- Reset asserted mid-frame: at the next edge the FSM returns to `IDLE` and all outputs take their reset values. No `done` pulse and no further beats are produced.
- `core_ready` is ignored outside `STREAM`.

## Timing
- `start` sampled at edge 0:
  - `cfifo_cfg` high in cycle 1.
  - First `X_rd` in cycle 2; first `cfifo_dvalid` in cycle 3.
- With no stalls, for N=`img_w`*`img_h`:
  - Last `X_rd` in cycle N+1.
  - Last `cfifo_dvalid` in cycle N+2 (`DRAIN`).
  - `done` in cycle N+3.
  - `ready`=1 from cycle N+4.
- Each stall cycle delays every later event by one cycle.
- Rejected start: `done`=1 and `err`=1 in cycle 1, `ready` again in cycle 2. No CFIFO strobe and no reads occur.
- `start` held high continuously starts back-to-back frames, one each time `ready` is seen.

## Test plan
- **4x4 frame, no stall.** `x_base`=0x100, `y_base`=0x200, `core_ready`=1.
  - `X_rd` 0x100..0x10F in cycles 2..17.
  - `cfifo_dvalid` in cycles 3..18.
  - `win_valid` on beats 11,12,15,16 with `Y_wr` 0x200..0x203.
  - `done` in cycle 19.
- **Stall.** Same frame with `core_ready`=0 in cycles 5..7.
  - `X_rd` holds 0x103.
  - `cfifo_dvalid` low in cycles 6..8.
  - `done` in cycle 22.
  - Total `win_valid` count is 4.
- **Dimension error.** `img_w`=2.
  - `err`=1 and `done`=1 in cycle 1.
  - `cfifo_cfg` never asserted.
  - `ready` in cycle 2.
  - The next valid start clears `err`.
- **Address wrap.** `x_base`=0xFFE with a 3x3 frame.
  - `X_rd` sequence is 0xFFE, 0xFFF, 0x000..0x006.
  - Exactly one `win_valid`, at `Y_wr`=`y_base`.
- **Reset mid-frame.** `rst_n`=0 in cycle 8 of a 4x4 run.
  - From the next cycle, all outputs are at reset values with `ready`=1 and no `done`.
  - A following start runs a clean frame.
- **Start while busy.** `start` pulsed in cycle 5 of a run is ignored; exactly one `done` is produced.
